cp0_unit: RTL and testbench



---
 rtl/cp0_unit.sv | 142 ++++++++++++++
 tb/tb_cp0_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_unit.sv
// Coprocessor-0 for the P7 pipeline.
// Holds SR, Cause and EPC. Decides interrupt/exception entry from the Bridge
// interrupt lines and the M-stage exception code, and raises Req so the CPU
// can flush, redirect fetch to the handler and gate peripheral writes.
// Also serves mfc0 reads, mtc0 writes and eret from the M stage.
module cp0_unit #(
  parameter logic [4:0] SR_ADDR    = 5'd12,
  parameter logic [4:0] CAUSE_ADDR = 5'd13,
  parameter logic [4:0] EPC_ADDR   = 5'd14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] DOut,
  output logic [31:0] EPCOut,
  output logic        Req
);

  // Only the architecturally defined fields are stored; every other bit of
  // SR and Cause is a constant zero on read.
  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc_code;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic        sr_write;
  logic        epc_write;
  logic [31:0] sr_packed;
  logic [31:0] cause_packed;
  logic [31:0] entry_epc;

  // Entry request: a masked interrupt or any exception, both blocked while
  // the handler is already running (EXL=1) so entry never nests.
  always_comb begin
    int_req = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
    exc_req = (ExcCodeIn != 5'd0) & ~sr_exl;
    Req     = int_req | exc_req;
  end

  // mtc0 is suppressed whenever entry happens in the same cycle, so the
  // faulting/interrupted instruction never commits its CP0 write.
  always_comb begin
    sr_write  = WE & ~Req & (A2 == SR_ADDR);
    epc_write = WE & ~Req & (A2 == EPC_ADDR);
  end

  // A delay-slot instruction restarts at its branch, one word earlier;
  // the subtraction wraps naturally in 32 bits.
  always_comb begin
    entry_epc = BDIn ? (PC - 32'd4) : PC;
  end

  // Packed register views used by mfc0.
  always_comb begin
    sr_packed    = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
    cause_packed = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc_code, 2'd0};
  end

  // mfc0 read mux: returns the pre-edge register contents, no write bypass.
  always_comb begin
    // NOTE: default assignment first so every path drives DOut and no latch is inferred.
    DOut = 32'd0;
    if (A1 == SR_ADDR) begin
      DOut = sr_packed;
    end else if (A1 == CAUSE_ADDR) begin
      DOut = cause_packed;
    end else if (A1 == EPC_ADDR) begin
      DOut = epc;
    end
  end

  assign EPCOut = epc;

  // Cause.IP tracks the raw interrupt lines every cycle, independent of
  // entry, EXL or mtc0.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    if (reset) begin
      cause_ip <= 6'd0;
    end else begin
      cause_ip <= HWInt;
    end
  end

  // SR update: entry sets EXL; otherwise mtc0 loads the fields and eret
  // clears EXL, with eret taking precedence for EXL when both occur.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im  <= 6'd0;
      sr_exl <= 1'b0;
      sr_ie  <= 1'b0;
    end else if (Req) begin
      sr_exl <= 1'b1;
    end else begin
      if (sr_write) begin
        sr_im  <= DIn[15:10];
        sr_exl <= DIn[1];
        sr_ie  <= DIn[0];
      end
      if (EXLClr) begin
        sr_exl <= 1'b0;
      end
    end
  end

  // Cause.BD and Cause.ExcCode are captured only at entry; an interrupt
  // reports code 0 even if an exception is pending in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cause_bd       <= 1'b0;
      cause_exc_code <= 5'd0;
    end else if (Req) begin
      cause_bd       <= BDIn;
      cause_exc_code <= int_req ? 5'd0 : ExcCodeIn;
    end
  end

  // EPC: loaded with the restart address at entry, or by mtc0 otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      epc <= 32'd0;
    end else if (Req) begin
      epc <= entry_epc;
    end else if (epc_write) begin
      epc <= DIn;
    end
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed scenarios followed by random
// traffic, all compared against a word-level reference model of CP0.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] PC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] DOut;
  logic [31:0] EPCOut;
  logic        Req;

  int errors = 0;
  int checks = 0;

  // Reference model state: whole 32-bit register images.
  logic [31:0] m_sr;
  logic [31:0] m_cause;
  logic [31:0] m_epc;

  cp0_unit dut (
    .clk       (clk),
    .reset     (reset),
    .A1        (A1),
    .A2        (A2),
    .DIn       (DIn),
    .WE        (WE),
    .PC        (PC),
    .BDIn      (BDIn),
    .ExcCodeIn (ExcCodeIn),
    .HWInt     (HWInt),
    .EXLClr    (EXLClr),
    .DOut      (DOut),
    .EPCOut    (EPCOut),
    .Req       (Req)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_int();
    return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return m_int() || ((ExcCodeIn != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  // Next model state from the current inputs and model state.
  task automatic m_update();
    logic req;
    logic intr;
    req  = m_req();
    intr = m_int();
    if (reset) begin
      m_sr    = 32'd0;
      m_cause = 32'd0;
      m_epc   = 32'd0;
    end else begin
      m_cause = (m_cause & ~32'h0000_FC00) | (32'(HWInt) << 10);
      if (req) begin
        m_sr    = m_sr | 32'h2;
        m_cause = (m_cause & 32'h0000_FC00) | (BDIn ? 32'h8000_0000 : 32'h0)
                | (intr ? 32'h0 : (32'(ExcCodeIn) << 2));
        m_epc   = BDIn ? PC - 32'd4 : PC;
      end else begin
        if (WE && A2 == 5'd12) m_sr = DIn & 32'h0000_FC03;
        if (WE && A2 == 5'd14) m_epc = DIn;
        if (EXLClr) m_sr = m_sr & ~32'h2;
      end
    end
  endtask

  task automatic set_in(input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] din,
                        input logic we, input logic [31:0] pc, input logic bd,
                        input logic [4:0] exc, input logic [5:0] hw, input logic clr);
    A1 = a1; A2 = a2; DIn = din; WE = we; PC = pc; BDIn = bd;
    ExcCodeIn = exc; HWInt = hw; EXLClr = clr;
  endtask

  // Called just after a falling edge with inputs applied: check outputs
  // against the model, advance one clock, return after the next falling edge.
  task automatic step();
    #1;
    check("req", 32'(Req), 32'(m_req()));
    check("dout", DOut, m_read(A1));
    check("epcout", EPCOut, m_epc);
    m_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic peek(input string tag, input logic [4:0] a1, input logic [31:0] exp);
    A1 = a1;
    #1;
    check(tag, DOut, exp);
  endtask

  initial begin
    // Bring the DUT out of the unknown power-up state.
    reset = 1'b1;
    set_in(5'd0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
    step();
    reset = 1'b0;

    // Reset state: everything reads zero, interrupts masked by IE=0.
    peek("rst_sr", 5'd12, 32'd0);
    peek("rst_cause", 5'd13, 32'd0);
    peek("rst_epc", 5'd14, 32'd0);
    check("rst_epcout", EPCOut, 32'd0);
    HWInt = 6'b000001;
    #1;
    check("rst_req_ie0", 32'(Req), 32'd0);
    step();

    // Enable Timer0 interrupt, then take it.
    set_in(5'd12, 5'd12, 32'h0000_0401, 1'b1, 32'h0000_3000, 1'b0, 5'd0, 6'd0, 1'b0);
    step();
    set_in(5'd13, 5'd0, 32'd0, 1'b0, 32'h0000_3010, 1'b0, 5'd0, 6'b000001, 1'b0);
    #1;
    check("int_req", 32'(Req), 32'd1);
    step();
    HWInt = 6'd0;
    check("int_epc", EPCOut, 32'h0000_3010);
    peek("int_cause", 5'd13, 32'h0000_0400);
    peek("int_sr", 5'd12, 32'h0000_0403);
    step();

    // eret, then disable IE, then a delay-slot exception.
    set_in(5'd12, 5'd0, 32'd0, 1'b0, 32'h0000_3014, 1'b0, 5'd0, 6'd0, 1'b1);
    step();
    set_in(5'd12, 5'd12, 32'd0, 1'b1, 32'h0000_3018, 1'b0, 5'd0, 6'd0, 1'b0);
    step();
    set_in(5'd13, 5'd0, 32'd0, 1'b0, 32'h0000_3020, 1'b1, 5'd10, 6'd0, 1'b0);
    #1;
    check("exc_req", 32'(Req), 32'd1);
    step();
    check("exc_epc", EPCOut, 32'h0000_301C);
    peek("exc_cause", 5'd13, 32'h8000_0028);

    // Nested entry blocked while EXL=1.
    set_in(5'd14, 5'd0, 32'd0, 1'b0, 32'h0000_3030, 1'b0, 5'd4, 6'b111111, 1'b0);
    #1;
    check("nest_req", 32'(Req), 32'd0);
    step();
    check("nest_epc", EPCOut, 32'h0000_301C);
    EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;
    #1;
    check("eret_reassert", 32'(Req), 32'd1);
    step();

    // eret, re-enable Timer0, then interrupt collides with mtc0 EPC.
    set_in(5'd12, 5'd0, 32'd0, 1'b0, 32'h0000_3034, 1'b0, 5'd0, 6'd0, 1'b1);
    step();
    set_in(5'd12, 5'd12, 32'h0000_0401, 1'b1, 32'h0000_3038, 1'b0, 5'd0, 6'd0, 1'b0);
    step();
    set_in(5'd14, 5'd14, 32'h1234_5678, 1'b1, 32'h0000_3040, 1'b0, 5'd0, 6'b000001, 1'b0);
    #1;
    check("coll_req", 32'(Req), 32'd1);
    step();
    check("coll_epc", EPCOut, 32'h0000_3040);

    // mtc0 to Cause has no effect.
    set_in(5'd13, 5'd13, 32'hFFFF_FFFF, 1'b1, 32'h0000_3044, 1'b0, 5'd0, 6'b000001, 1'b0);
    step();
    peek("cause_ro", 5'd13, 32'h0000_0400);

    // eret, then reset in the same cycle as a pending interrupt.
    set_in(5'd12, 5'd0, 32'd0, 1'b0, 32'h0000_3048, 1'b0, 5'd0, 6'b000001, 1'b1);
    step();
    EXLClr = 1'b0;
    #1;
    check("rst_coll_req", 32'(Req), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    HWInt = 6'd0;
    peek("rst2_sr", 5'd12, 32'd0);
    peek("rst2_cause", 5'd13, 32'd0);
    peek("rst2_epc", 5'd14, 32'd0);
    check("rst2_epcout", EPCOut, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [31:0] pc;
      a1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 2));
      a2 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 2));
      pc = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom & 32'hFFFF_FFFC);
      set_in(a1, a2, $urandom, 1'($urandom), pc, 1'($urandom),
             ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0,
             6'($urandom), ($urandom_range(0, 3) == 0));
      reset = ($urandom_range(0, 49) == 0);
      step();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
